param_syncram: RTL and testbench

- Parametrised single-clock RAM with one write port and one read port, and a registered read output with a valid strobe.
- Contents are cleared by a hardware sweep, one word per cycle, after reset or on request. This replaces any single-cycle bulk clear.
- Read-during-write collision policy is selectable by parameter.
- Generic storage primitive for buffers and register files across the design.

---
 rtl/param_syncram_pkg.sv | 23 ++
 rtl/param_syncram_clr_ctl.sv | 67 ++++++
 rtl/param_syncram.sv | 126 ++++++++++++
 tb/tb_param_syncram.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/param_syncram_pkg.sv
// Shared types and helpers for param_syncram.
//   state_t     : clear-sweep FSM states (CLEAR, READY)
//   RDW_OLD/NEW : read-during-write policy encodings for RDW_MODE
//   even_parity : reduction-XOR parity of a zero-extended word
package param_syncram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  // Widest data word the parity helper accepts; narrower words are
  // zero-extended by the caller, which leaves the parity unchanged.
  localparam int unsigned PAR_MAX_W = 256;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/param_syncram_clr_ctl.sv
// Clear-sweep controller for param_syncram.
// Walks a pointer over every word once per sweep, asserting a clear write
// each cycle; a sweep runs after reset and on init request from READY.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_init_req    : start a new sweep (honoured only in READY)
//   o_busy        : high while the sweep runs
//   o_clr_we      : clear write strobe for mem[o_ptr]
//   o_ptr         : AW+1 bit sweep pointer (low AW bits address memory)
module param_syncram_clr_ctl
  import param_syncram_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init_req,
  output logic        o_busy,
  output logic        o_clr_we,
  output logic [AW:0] o_ptr
);

  localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  state_t      r_state;
  logic [AW:0] r_ptr;
  logic        r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_ptr == LAST) begin
            r_state <= READY;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_ptr <= r_ptr + ONE;
          end
        end
        READY: begin
          if (i_init_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_ptr    = r_ptr;
  // Memory must not be written while reset is held, even though the FSM
  // already sits in CLEAR.
  assign o_clr_we = r_busy & ~i_rst;

endmodule

// File: rtl/param_syncram.sv
// Parametrised single-clock RAM: one write port, one registered read port
// with valid strobe, hardware clear sweep after reset / on init_req, and a
// selectable read-during-write policy (RDW_MODE: 0 old data, 1 new data).
// Optional per-word even parity with error injection when the macro
// PARAM_SYNCRAM_PARITY_EN is defined; otherwise perr is tied low.
//   clk, rst           : clock, synchronous active-high reset
//   init_req / busy    : sweep request / sweep in progress (we, re dropped)
//   we, waddr, din     : write port; inj_perr flips stored parity
//   re, raddr          : read request
//   dout, dout_valid   : registered read data and one-cycle valid
//   perr               : parity error, aligned with dout_valid
module param_syncram
  import param_syncram_pkg::*;
#(
  parameter int unsigned    DW       = 8,
  parameter int unsigned    AW       = 4,
  parameter int unsigned    RDW_MODE = 0,
  parameter logic [DW-1:0]  INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_req,
  output logic          busy,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic          inj_perr,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          perr
);

  localparam int unsigned DEPTH = 2 ** AW;
`ifdef PARAM_SYNCRAM_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif

  logic [MW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;
  logic          r_dout_valid;

  logic          w_busy;
  logic          w_clr_we;
  logic [AW:0]   w_ptr;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic          w_bypass;
  logic [MW-1:0] w_wr_word;
  logic [MW-1:0] w_init_word;
  logic [MW-1:0] w_rd_word;
  logic          w_unused;

  param_syncram_clr_ctl #(
    .AW(AW)
  ) u_clr_ctl (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_init_req (init_req),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_ptr      (w_ptr)
  );

  assign w_wr_ok  = we & ~w_busy & ~rst;
  assign w_rd_ok  = re & ~w_busy;
  assign w_bypass = (RDW_MODE == RDW_NEW) && w_wr_ok && (waddr == raddr);

`ifdef PARAM_SYNCRAM_PARITY_EN
  assign w_wr_word   = {even_parity(PAR_MAX_W'(din)) ^ inj_perr, din};
  assign w_init_word = {even_parity(PAR_MAX_W'(INIT_VAL)), INIT_VAL};
  assign w_unused    = w_ptr[AW];
`else
  assign w_wr_word   = din;
  assign w_init_word = INIT_VAL;
  assign w_unused    = ^{w_ptr[AW], inj_perr};
`endif

  // Write-first bypass returns the word being written, including its
  // (possibly injected) parity bit.
  assign w_rd_word = w_bypass ? w_wr_word : r_mem[raddr];

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_ptr[AW-1:0]] <= w_init_word;
    end else if (w_wr_ok) begin
      r_mem[waddr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_dout <= w_rd_word[DW-1:0];
      end
    end
  end

`ifdef PARAM_SYNCRAM_PARITY_EN
  logic r_perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (w_rd_ok) begin
      r_perr <= even_parity(PAR_MAX_W'(w_rd_word[DW-1:0])) ^ w_rd_word[DW];
    end
  end

  assign perr = r_perr;
`else
  assign perr = 1'b0;
`endif

  assign busy       = w_busy;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_param_syncram.sv
module tb_param_syncram;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, init_req, we, re, inj_perr;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] din;
  logic          busy0, busy1, v0, v1, p0, p1;
  logic [DW-1:0] d0, d1;

  param_syncram #(.DW(DW), .AW(AW), .RDW_MODE(0), .INIT_VAL(8'h00)) u_old (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy0),
    .we(we), .waddr(waddr), .din(din), .inj_perr(inj_perr),
    .re(re), .raddr(raddr), .dout(d0), .dout_valid(v0), .perr(p0)
  );

  param_syncram #(.DW(DW), .AW(AW), .RDW_MODE(1), .INIT_VAL(8'h00)) u_new (
    .clk(clk), .rst(rst), .init_req(init_req), .busy(busy1),
    .we(we), .waddr(waddr), .din(din), .inj_perr(inj_perr),
    .re(re), .raddr(raddr), .dout(d1), .dout_valid(v1), .perr(p1)
  );

  typedef struct {
    logic [7:0] e0;
    logic [7:0] e1;
    logic       ep;
    string      nm;
  } exp_t;

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [7:0] din;
    logic       re;
    logic [3:0] raddr;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; init_req = 1'b0; inj_perr = 1'b0;
  endtask

  // One clock; afterwards score any read issued in the elapsed cycle.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({e.nm, "_valid"}, {v0, v1}, 2'b11);
      chk({e.nm, "_dout_old"}, d0, e.e0);
      chk({e.nm, "_dout_new"}, d1, e.e1);
      chk({e.nm, "_perr"}, {p0, p1}, {e.ep, e.ep});
    end else begin
      chk("idle_valid", {v0, v1}, 2'b00);
    end
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] e0, input logic [7:0] e1,
                         input logic ep, input string nm);
    exp_t e;
    re = 1'b1; raddr = a;
    e.e0 = e0; e.e1 = e1; e.ep = ep; e.nm = nm;
    sbq.push_back(e);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      step();
      n++;
    end
  endtask

  vec_t vt[10];
  int   n;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  8'h00, 8'h00};
    vt[1] = '{1'b1, 4'd15, 8'h5A, 1'b0, 4'd0,  8'h00, 8'h00};
    vt[2] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  8'hA5, 8'hA5};
    vt[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 8'h5A, 8'h5A};
    vt[4] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd4,  8'h00, 8'h00};
    vt[5] = '{1'b1, 4'd7,  8'h11, 1'b0, 4'd0,  8'h00, 8'h00};
    vt[6] = '{1'b1, 4'd7,  8'h22, 1'b1, 4'd7,  8'h11, 8'h22};
    vt[7] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd7,  8'h22, 8'h22};
    vt[8] = '{1'b1, 4'd9,  8'hC3, 1'b1, 4'd3,  8'hA5, 8'hA5};
    vt[9] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd9,  8'hC3, 8'hC3};

    rst = 1'b1; idle(); waddr = '0; raddr = '0; din = '0;

    // Reset state and post-reset sweep length
    repeat (3) step();
    chk("rst_busy", {busy0, busy1}, 2'b11);
    chk("rst_dout", {d0, d1}, 16'h0000);
    chk("rst_perr", {p0, p1}, 2'b00);
    rst = 1'b0;
    count_busy(n);
    chk("sweep_len_after_rst", n, DEPTH);
    chk("busy_new_done", busy1, 1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      do_read(4'(i), 8'h00, 8'h00, 1'b0, "init_read");
      step(); idle();
    end

    // Table-driven write/read/collision vectors
    for (int i = 0; i < 10; i++) begin
      we = vt[i].we; waddr = vt[i].waddr; din = vt[i].din;
      if (vt[i].re) do_read(vt[i].raddr, vt[i].e0, vt[i].e1, 1'b0, $sformatf("vec%0d", i));
      step(); idle();
    end
    step();
    chk("dout_hold", {d0, d1}, 16'hC3C3);

    // Busy gating: accesses during a sweep are dropped
    we = 1'b1; waddr = 4'd2; din = 8'hFF; step(); idle();
    chk("ready_before_init", busy0, 1'b0);
    init_req = 1'b1; step(); idle();
    chk("busy_after_init", {busy0, busy1}, 2'b11);
    we = 1'b1; waddr = 4'd5; din = 8'h33; re = 1'b1; raddr = 4'd2;
    step(); idle();
    count_busy(n);
    chk("sweep_len_after_init", n + 1, DEPTH);
    do_read(4'd2, 8'h00, 8'h00, 1'b0, "gated_addr2"); step(); idle();
    do_read(4'd5, 8'h00, 8'h00, 1'b0, "gated_addr5"); step(); idle();

    // Reset mid-sweep restarts a full sweep; init_req during CLEAR ignored
    we = 1'b1; waddr = 4'd12; din = 8'h77; step(); idle();
    do_read(4'd12, 8'h77, 8'h77, 1'b0, "pre_rst_addr12"); step(); idle();
    init_req = 1'b1; step(); idle();
    repeat (7) step();
    rst = 1'b1; step(); step();
    chk("midrst_busy", {busy0, busy1}, 2'b11);
    chk("midrst_dout", {d0, d1}, 16'h0000);
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      if (n == 4) init_req = 1'b1;
      step();
      init_req = 1'b0;
      n++;
    end
    chk("sweep_len_mid_rst", n, DEPTH);
    do_read(4'd12, 8'h00, 8'h00, 1'b0, "midrst_addr12"); step(); idle();

`ifdef PARAM_SYNCRAM_PARITY_EN
    we = 1'b1; waddr = 4'd1; din = 8'h0F; inj_perr = 1'b1; step(); idle();
    do_read(4'd1, 8'h0F, 8'h0F, 1'b1, "par_inj"); step(); idle();
    we = 1'b1; waddr = 4'd1; din = 8'h0F; inj_perr = 1'b0; step(); idle();
    do_read(4'd1, 8'h0F, 8'h0F, 1'b0, "par_clean"); step(); idle();
`endif

    step();
    chk("scoreboard_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
